// File: rtl/hazard_scoreboard_fwd.sv
// ID-stage hazard unit: forwards GPR data from younger pipeline stages, detects load-use hazards
// and tracks outstanding long-latency destinations in a 32-entry busy scoreboard.
module hazard_scoreboard_fwd #(
    parameter int XLEN     = 32,
    parameter int NREAD    = 2,
    parameter int NSTAGE   = 3,
    parameter int SB_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*5-1:0]      id_reg_raddr_i,
    input  logic [NREAD-1:0]        id_reg_re_i,
    input  logic [NSTAGE*5-1:0]     stg_reg_waddr_i,
    input  logic [NSTAGE*XLEN-1:0]  stg_reg_wdata_i,
    input  logic [NSTAGE-1:0]       stg_reg_we_i,
    input  logic [NSTAGE-1:0]       stg_data_vld_i,
    input  logic                    lu_issue_i,
    input  logic [4:0]              lu_issue_rd_i,
    input  logic                    lu_done_i,
    input  logic [4:0]              lu_done_rd_i,
    input  logic                    lu_flush_i,
    output logic [NREAD-1:0]        dhnf_hazard_sel_o,
    output logic [NREAD*XLEN-1:0]   dhnf_forward_data_o,
    output logic                    dhnf_stall_o,
    output logic [31:0]             sb_busy_o,
    output logic                    sb_full_o,
    output logic                    sb_err_o
);

    localparam int CW = $clog2(SB_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(SB_DEPTH);

    logic [31:0]      sb_busy, busy_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic             sb_err;
    logic [NREAD-1:0] lu_stall, sb_stall;
    logic [4:0]       rd;
    logic             rd_ok, hit, hit_vld;
    logic [XLEN-1:0]  hit_data;
    logic             done_ok, issue_free, issue_room, issue_ok, issue_err, done_err;

    // Stages are scanned oldest to youngest so the youngest matching stage overwrites the rest.
    always_comb begin
        dhnf_hazard_sel_o   = '0;
        dhnf_forward_data_o = '0;
        lu_stall            = '0;
        sb_stall            = '0;
        rd                  = '0;
        rd_ok               = 1'b0;
        hit                 = 1'b0;
        hit_vld             = 1'b0;
        hit_data            = '0;
        for (int p = 0; p < NREAD; p++) begin
            rd       = id_reg_raddr_i[p*5 +: 5];
            rd_ok    = id_reg_re_i[p] && (rd != 5'd0);
            hit      = 1'b0;
            hit_vld  = 1'b0;
            hit_data = '0;
            for (int s = NSTAGE - 1; s >= 0; s--) begin
                if (rd_ok && stg_reg_we_i[s] && (stg_reg_waddr_i[s*5 +: 5] == rd)) begin
                    hit      = 1'b1;
                    hit_vld  = stg_data_vld_i[s];
                    hit_data = stg_reg_wdata_i[s*XLEN +: XLEN];
                end
            end
            if (hit && hit_vld) begin
                dhnf_hazard_sel_o[p]              = 1'b1;
                dhnf_forward_data_o[p*XLEN +: XLEN] = hit_data;
            end else if (hit) begin
                lu_stall[p] = 1'b1;
            end
            sb_stall[p] = rd_ok && sb_busy[rd];
        end
    end

    // A done retiring the same register or freeing a slot lets a same-cycle issue through.
    always_comb begin
        done_ok    = lu_done_i && sb_busy[lu_done_rd_i];
        done_err   = lu_done_i && !sb_busy[lu_done_rd_i];
        issue_free = !sb_busy[lu_issue_rd_i] || (done_ok && (lu_done_rd_i == lu_issue_rd_i));
        issue_room = (count < DEPTH_C) || done_ok;
        issue_ok   = lu_issue_i && (lu_issue_rd_i != 5'd0) && issue_free && issue_room;
        issue_err  = lu_issue_i && (lu_issue_rd_i != 5'd0) && !(issue_free && issue_room);
        busy_nxt   = sb_busy;
        count_nxt  = count;
        if (done_ok)
            busy_nxt[lu_done_rd_i] = 1'b0;
        if (issue_ok)
            busy_nxt[lu_issue_rd_i] = 1'b1;
        if (issue_ok && !done_ok)
            count_nxt = count + CW'(1);
        else if (done_ok && !issue_ok)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_busy <= '0;
            count   <= '0;
            sb_err  <= 1'b0;
        end else if (lu_flush_i) begin
            sb_busy <= '0;
            count   <= '0;
        end else begin
            sb_busy <= busy_nxt;
            count   <= count_nxt;
            sb_err  <= sb_err | issue_err | done_err;
        end
    end

    assign sb_busy_o    = sb_busy;
    assign sb_full_o    = (count == DEPTH_C);
    assign sb_err_o     = sb_err;
    assign dhnf_stall_o = (|(lu_stall | sb_stall)) | (lu_issue_i & sb_full_o);

endmodule

// File: tb/tb_hazard_scoreboard_fwd.sv
// Directed bench for hazard_scoreboard_fwd: expected outputs are queued when each step is driven
// and popped for comparison on the following falling edge.
module tb_hazard_scoreboard_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  id_reg_raddr_i;
    logic [1:0]  id_reg_re_i;
    logic [14:0] stg_reg_waddr_i;
    logic [95:0] stg_reg_wdata_i;
    logic [2:0]  stg_reg_we_i;
    logic [2:0]  stg_data_vld_i;
    logic        lu_issue_i;
    logic [4:0]  lu_issue_rd_i;
    logic        lu_done_i;
    logic [4:0]  lu_done_rd_i;
    logic        lu_flush_i;
    logic [1:0]  dhnf_hazard_sel_o;
    logic [63:0] dhnf_forward_data_o;
    logic        dhnf_stall_o;
    logic [31:0] sb_busy_o;
    logic        sb_full_o;
    logic        sb_err_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [63:0] data;
        logic        stall;
        logic [31:0] busy;
        logic        full;
        logic        err;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    hazard_scoreboard_fwd #(.XLEN(32), .NREAD(2), .NSTAGE(3), .SB_DEPTH(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .id_reg_raddr_i      (id_reg_raddr_i),
        .id_reg_re_i         (id_reg_re_i),
        .stg_reg_waddr_i     (stg_reg_waddr_i),
        .stg_reg_wdata_i     (stg_reg_wdata_i),
        .stg_reg_we_i        (stg_reg_we_i),
        .stg_data_vld_i      (stg_data_vld_i),
        .lu_issue_i          (lu_issue_i),
        .lu_issue_rd_i       (lu_issue_rd_i),
        .lu_done_i           (lu_done_i),
        .lu_done_rd_i        (lu_done_rd_i),
        .lu_flush_i          (lu_flush_i),
        .dhnf_hazard_sel_o   (dhnf_hazard_sel_o),
        .dhnf_forward_data_o (dhnf_forward_data_o),
        .dhnf_stall_o        (dhnf_stall_o),
        .sb_busy_o           (sb_busy_o),
        .sb_full_o           (sb_full_o),
        .sb_err_o            (sb_err_o)
    );

    always #5 clk = ~clk;

    task automatic idle();
        id_reg_raddr_i  = '0;
        id_reg_re_i     = '0;
        stg_reg_waddr_i = '0;
        stg_reg_wdata_i = '0;
        stg_reg_we_i    = '0;
        stg_data_vld_i  = '0;
        lu_issue_i      = 1'b0;
        lu_issue_rd_i   = '0;
        lu_done_i       = 1'b0;
        lu_done_rd_i    = '0;
        lu_flush_i      = 1'b0;
    endtask

    task automatic setRead(input int p, input logic [4:0] a);
        id_reg_raddr_i[p*5 +: 5] = a;
        id_reg_re_i[p]           = 1'b1;
    endtask

    task automatic setStage(input int s, input logic [4:0] a, input logic [31:0] d, input logic vld);
        stg_reg_waddr_i[s*5 +: 5]  = a;
        stg_reg_wdata_i[s*32 +: 32] = d;
        stg_reg_we_i[s]            = 1'b1;
        stg_data_vld_i[s]          = vld;
    endtask

    task automatic issue(input logic [4:0] a);
        lu_issue_i    = 1'b1;
        lu_issue_rd_i = a;
    endtask

    task automatic done(input logic [4:0] a);
        lu_done_i    = 1'b1;
        lu_done_rd_i = a;
    endtask

    task automatic applyStimulus(input string tag, input logic [1:0] sel, input logic [63:0] data,
                                 input logic stall, input logic [31:0] busy, input logic full,
                                 input logic err);
        exp_t e;
        e.sel = sel; e.data = data; e.stall = stall; e.busy = busy; e.full = full; e.err = err;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic cmp(input string tag, input string field, input logic [63:0] obs,
                       input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
        end
    endtask

    // Compares on the falling edge, then advances to just after the next rising edge.
    task automatic checkOutput();
        exp_t  e;
        string tag;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL queue_empty observed=0 expected=1");
        end else begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            cmp(tag, "sel",   64'(dhnf_hazard_sel_o),   64'(e.sel));
            cmp(tag, "data",  dhnf_forward_data_o,      e.data);
            cmp(tag, "stall", 64'(dhnf_stall_o),        64'(e.stall));
            cmp(tag, "busy",  64'(sb_busy_o),           64'(e.busy));
            cmp(tag, "full",  64'(sb_full_o),           64'(e.full));
            cmp(tag, "err",   64'(sb_err_o),            64'(e.err));
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] B2 = 32'h1 << 2;
    localparam logic [31:0] B3 = 32'h1 << 3;
    localparam logic [31:0] B4 = 32'h1 << 4;
    localparam logic [31:0] B6 = 32'h1 << 6;
    localparam logic [31:0] B9 = 32'h1 << 9;

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        idle(); applyStimulus("reset", 2'b00, 64'h0, 0, 32'h0, 0, 0); checkOutput();

        idle(); setStage(0, 5'd5, 32'hAAAA, 1); setStage(1, 5'd5, 32'hBBBB, 1);
        setRead(0, 5'd5); setRead(1, 5'd6);
        applyStimulus("fwd_youngest", 2'b01, 64'h0000_AAAA, 0, 32'h0, 0, 0); checkOutput();

        idle(); setStage(0, 5'd7, 32'h5678, 0); setStage(1, 5'd7, 32'h1234, 1); setRead(0, 5'd7);
        applyStimulus("load_use", 2'b00, 64'h0, 1, 32'h0, 0, 0); checkOutput();

        idle(); setStage(0, 5'd7, 32'h5678, 1); setStage(1, 5'd7, 32'h1234, 1); setRead(0, 5'd7);
        applyStimulus("load_ready", 2'b01, 64'h5678, 0, 32'h0, 0, 0); checkOutput();

        idle(); setStage(2, 5'd8, 32'hCAFE, 1); setRead(1, 5'd8); setRead(0, 5'd1);
        applyStimulus("fwd_wb_p1", 2'b10, 64'h0000_CAFE_0000_0000, 0, 32'h0, 0, 0); checkOutput();

        idle(); setStage(0, 5'd0, 32'h11, 0); setStage(1, 5'd0, 32'h22, 1); setStage(2, 5'd0, 32'h33, 1);
        setRead(0, 5'd0); setRead(1, 5'd0);
        applyStimulus("read_x0", 2'b00, 64'h0, 0, 32'h0, 0, 0); checkOutput();

        idle(); setStage(0, 5'd5, 32'h99, 1); id_reg_raddr_i[4:0] = 5'd5;
        applyStimulus("re_off", 2'b00, 64'h0, 0, 32'h0, 0, 0); checkOutput();

        idle(); issue(5'd9);
        applyStimulus("issue_x9", 2'b00, 64'h0, 0, 32'h0, 0, 0); checkOutput();
        idle(); setRead(0, 5'd9);
        applyStimulus("sb_stall", 2'b00, 64'h0, 1, B9, 0, 0); checkOutput();
        idle(); setRead(0, 5'd9); done(5'd9);
        applyStimulus("done_no_bypass", 2'b00, 64'h0, 1, B9, 0, 0); checkOutput();
        idle(); setRead(0, 5'd9);
        applyStimulus("after_done", 2'b00, 64'h0, 0, 32'h0, 0, 0); checkOutput();

        idle(); issue(5'd3);
        applyStimulus("issue_x3", 2'b00, 64'h0, 0, 32'h0, 0, 0); checkOutput();
        idle(); issue(5'd4);
        applyStimulus("issue_x4", 2'b00, 64'h0, 0, B3, 0, 0); checkOutput();
        idle(); issue(5'd6);
        applyStimulus("issue_full", 2'b00, 64'h0, 1, B3 | B4, 1, 0); checkOutput();
        idle(); issue(5'd6); done(5'd3);
        applyStimulus("issue_done_full", 2'b00, 64'h0, 1, B3 | B4, 1, 1); checkOutput();
        idle();
        applyStimulus("after_swap", 2'b00, 64'h0, 0, B4 | B6, 1, 1); checkOutput();

        idle(); lu_flush_i = 1'b1; issue(5'd12);
        applyStimulus("flush_1", 2'b00, 64'h0, 1, B4 | B6, 1, 1); checkOutput();
        idle(); issue(5'd10);
        applyStimulus("after_flush_1", 2'b00, 64'h0, 0, 32'h0, 0, 1); checkOutput();
        idle(); issue(5'd11);
        applyStimulus("issue_x11", 2'b00, 64'h0, 0, 32'h1 << 10, 0, 1); checkOutput();
        idle(); lu_flush_i = 1'b1;
        applyStimulus("flush_2", 2'b00, 64'h0, 0, (32'h1 << 10) | (32'h1 << 11), 1, 1); checkOutput();
        idle(); issue(5'd12);
        applyStimulus("after_flush_2", 2'b00, 64'h0, 0, 32'h0, 0, 1); checkOutput();

        idle(); rst = 1'b1; issue(5'd13);
        applyStimulus("mid_reset", 2'b00, 64'h0, 0, 32'h1 << 12, 0, 1); checkOutput();
        rst = 1'b0;
        idle(); issue(5'd0);
        applyStimulus("after_reset", 2'b00, 64'h0, 0, 32'h0, 0, 0); checkOutput();
        idle(); issue(5'd2);
        applyStimulus("issue_x0_silent", 2'b00, 64'h0, 0, 32'h0, 0, 0); checkOutput();
        idle(); issue(5'd2);
        applyStimulus("waw_issue", 2'b00, 64'h0, 0, B2, 0, 0); checkOutput();
        idle(); issue(5'd2); done(5'd2);
        applyStimulus("waw_err", 2'b00, 64'h0, 0, B2, 0, 1); checkOutput();
        idle(); issue(5'd3);
        applyStimulus("same_rd_swap", 2'b00, 64'h0, 0, B2, 0, 1); checkOutput();
        idle();
        applyStimulus("count_two", 2'b00, 64'h0, 0, B2 | B3, 1, 1); checkOutput();

        idle(); rst = 1'b1;
        applyStimulus("reset_2", 2'b00, 64'h0, 0, B2 | B3, 1, 1); checkOutput();
        rst = 1'b0;
        idle(); done(5'd5);
        applyStimulus("bad_done", 2'b00, 64'h0, 0, 32'h0, 0, 0); checkOutput();
        idle();
        applyStimulus("bad_done_err", 2'b00, 64'h0, 0, 32'h0, 0, 1); checkOutput();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
